instruction_fetch: RTL

Instruction Fetch (IF) stage of the 32-bit MIPS pipeline, directly upstream of the Instruction Decode stage.
- Holds the PC register and a word-addressed instruction memory.
- Holds the IF/ID pipeline register, which drives the decode stage's Instruction input.
- Supports pipeline stall, branch redirect/flush, and a synchronous program-load write port for bring-up and testbenches.

---
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch.sv | 59 +++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: pipeline control and program-load inputs in, PC and IF/ID register contents out.
// The controller (master) drives Stall/BranchTaken/Imem*; the IF stage (slave) drives PC/Instruction/PCPlus4/InstrValid.
interface instruction_fetch_if #(
  parameter int BIT_DEPTH      = 32,
  parameter int LOG_IMEM_DEPTH = 8
);
  logic                      Stall;
  logic                      BranchTaken;
  logic [BIT_DEPTH-1:0]      BranchTarget;
  logic                      ImemWe;
  logic [LOG_IMEM_DEPTH-1:0] ImemWrAddr;
  logic [BIT_DEPTH-1:0]      ImemWrData;
  logic [BIT_DEPTH-1:0]      PC;
  logic [BIT_DEPTH-1:0]      Instruction;
  logic [BIT_DEPTH-1:0]      PCPlus4;
  logic                      InstrValid;

  modport master (
    output Stall, BranchTaken, BranchTarget, ImemWe, ImemWrAddr, ImemWrData,
    input  PC, Instruction, PCPlus4, InstrValid
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, ImemWe, ImemWrAddr, ImemWrData,
    output PC, Instruction, PCPlus4, InstrValid
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: PC register, word-addressed instruction memory and IF/ID register.
// Control semantics: each rising edge applies rst, else BranchTaken (redirect + bubble), else Stall (hold), else fetch.
module instruction_fetch #(
  parameter int                   BIT_DEPTH      = 32,
  parameter int                   LOG_IMEM_DEPTH = 8,
  parameter logic [BIT_DEPTH-1:0] RESET_PC       = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  instruction_fetch_if.slave bus
);
  localparam int IMEM_WORDS = 1 << LOG_IMEM_DEPTH;

  logic [BIT_DEPTH-1:0]      imem [IMEM_WORDS];
  logic [BIT_DEPTH-1:0]      pc_q;
  logic [BIT_DEPTH-1:0]      instr_q;
  logic [BIT_DEPTH-1:0]      pc_plus4_q;
  logic                      valid_q;
  logic [LOG_IMEM_DEPTH-1:0] fetch_idx;
  logic [BIT_DEPTH-1:0]      fetch_word;
  logic [BIT_DEPTH-1:0]      pc_next_seq;
  logic                      unused_target_bits;

  assign fetch_idx          = pc_q[LOG_IMEM_DEPTH+1:2];
  assign fetch_word         = imem[fetch_idx];
  assign pc_next_seq        = pc_q + BIT_DEPTH'(4);
  assign unused_target_bits = ^bus.BranchTarget[1:0];

  // Writes land on the edge, so a same-cycle fetch of that word still sees the old contents.
  always_ff @(posedge clk) begin
    if (bus.ImemWe) begin
      imem[bus.ImemWrAddr] <= bus.ImemWrData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (bus.BranchTaken) begin
      pc_q       <= {bus.BranchTarget[BIT_DEPTH-1:2], 2'b00};
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!bus.Stall) begin
      pc_q       <= pc_next_seq;
      instr_q    <= fetch_word;
      pc_plus4_q <= pc_next_seq;
      valid_q    <= 1'b1;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.Instruction = instr_q;
  assign bus.PCPlus4     = pc_plus4_q;
  assign bus.InstrValid  = valid_q;
endmodule
